// File: rtl/conv_pkg.sv
// Shared constants, widths and helpers for the KxK convolution engine.
package conv_pkg;

    // Default parameter values
    localparam int N_FILT_D = 8;
    localparam int N_CI_D   = 8;
    localparam int KSIZE_D  = 3;
    localparam int PIX_W_D  = 8;
    localparam int WT_W_D   = 8;
    localparam int ACC_W_D  = 32;

    localparam int KK_D       = KSIZE_D * KSIZE_D;
    localparam int CENTRE_TAP = (KK_D - 1) / 2;

    // Intermediate widths for the default configuration
    localparam int PROD_W_D = PIX_W_D + WT_W_D + 1;
    localparam int CSUM_W_D = PROD_W_D + $clog2(N_CI_D);
    localparam int TSUM_W_D = CSUM_W_D + $clog2(KK_D);

    typedef logic signed [ACC_W_D-1:0] acc_t;

    // Tap index inside the window, row-major.
    function automatic int tap_idx(input int row, input int col, input int ksize);
        return row * ksize + col;
    endfunction

    // Centre tap for an arbitrary odd kernel size.
    function automatic int centre_tap(input int ksize);
        return (ksize * ksize - 1) / 2;
    endfunction

endpackage

// File: rtl/conv_kxk_array_if.sv
// Beat-in / result-out stream bundle of the convolution engine.
interface conv_kxk_array_if
    import conv_pkg::*;
#(
    parameter int N_FILT = N_FILT_D,
    parameter int N_CI   = N_CI_D,
    parameter int KSIZE  = KSIZE_D,
    parameter int PIX_W  = PIX_W_D,
    parameter int WT_W   = WT_W_D,
    parameter int ACC_W  = ACC_W_D
);
    localparam int PIXV_W = KSIZE * KSIZE * N_CI * PIX_W;
    localparam int WTV_W  = KSIZE * KSIZE * N_CI * WT_W;

    logic                             valid_in;
    logic                             in_ready;
    logic                             last_channel;
    logic                             mode_1x1;
    logic [PIXV_W-1:0]                pixels;
    logic [N_FILT-1:0][WTV_W-1:0]     weights;
    logic [N_FILT-1:0][ACC_W-1:0]     biases;
    logic [N_FILT-1:0][ACC_W-1:0]     outs;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        output valid_in, last_channel, mode_1x1, pixels, weights, biases, out_ready,
        input  in_ready, outs, out_valid
    );

    modport slave (
        input  valid_in, last_channel, mode_1x1, pixels, weights, biases, out_ready,
        output in_ready, outs, out_valid
    );

endinterface

// File: rtl/conv_pe_lane.sv
// One filter's datapath: products, channel sums, tap sum + accumulator, bias add.
module conv_pe_lane
    import conv_pkg::*;
#(
    parameter int N_CI  = N_CI_D,
    parameter int KSIZE = KSIZE_D,
    parameter int PIX_W = PIX_W_D,
    parameter int WT_W  = WT_W_D,
    parameter int ACC_W = ACC_W_D
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_en,     // global advance (not stalled)
    input  logic                               i_take,   // beat accepted this edge
    input  logic                               i_mode,   // 1x1 mode of the incoming beat
    input  logic [KSIZE*KSIZE*N_CI*PIX_W-1:0]  i_pixels,
    input  logic [KSIZE*KSIZE*N_CI*WT_W-1:0]   i_weights,
    input  logic [ACC_W-1:0]                   i_bias,
    input  logic                               i_v1,     // S1 holds a beat
    input  logic                               i_v2,     // S2 holds a beat
    input  logic                               i_fresh,  // S3 restarts the accumulator
    input  logic                               i_emit,   // S3 holds a last beat
    output logic [ACC_W-1:0]                   o_out
);
    localparam int KK     = KSIZE * KSIZE;
    localparam int PROD_W = PIX_W + WT_W + 1;
    localparam int CSUM_W = PROD_W + $clog2(N_CI);
    localparam int TSUM_W = CSUM_W + $clog2(KK);
    localparam int CTAP   = centre_tap(KSIZE);

    logic signed [PROD_W-1:0] w_prod [KK][N_CI];
    logic signed [PROD_W-1:0] r_prod [KK][N_CI];
    logic signed [CSUM_W-1:0] w_csum [KK];
    logic signed [CSUM_W-1:0] r_csum [KK];
    logic signed [TSUM_W-1:0] w_tsum;
    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]         r_bias1, r_bias2, r_bias3;
    logic [ACC_W-1:0]         r_out;

    // S1 multipliers: unsigned pixel (zero-extended) times signed weight;
    // off-centre taps are forced to zero in 1x1 mode.
    for (genvar gr = 0; gr < KSIZE; gr++) begin : g_row
        for (genvar gc = 0; gc < KSIZE; gc++) begin : g_col
            for (genvar gch = 0; gch < N_CI; gch++) begin : g_ch
                localparam int T = tap_idx(gr, gc, KSIZE);
                localparam int B = T * N_CI + gch;
                logic signed [PROD_W-1:0] w_px;
                logic signed [PROD_W-1:0] w_wt;
                assign w_px = PROD_W'({1'b0, i_pixels[B*PIX_W +: PIX_W]});
                assign w_wt = PROD_W'($signed(i_weights[B*WT_W +: WT_W]));
                assign w_prod[T][gch] = (i_mode && (T != CTAP)) ? '0 : w_px * w_wt;
            end
        end
    end

    // S2 adder trees: per-tap sum across channels
    always_comb begin
        for (int t = 0; t < KK; t++) begin
            w_csum[t] = '0;
            for (int ch = 0; ch < N_CI; ch++)
                w_csum[t] = w_csum[t] + CSUM_W'(r_prod[t][ch]);
        end
    end

    // S3 adder tree: sum of taps, sign-extended to accumulator width
    always_comb begin
        w_tsum = '0;
        for (int t = 0; t < KK; t++)
            w_tsum = w_tsum + TSUM_W'(r_csum[t]);
        w_ext = ACC_W'(w_tsum);
    end

    // Datapath registers; a stage only loads when its source stage is valid
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_take) begin
                r_prod  <= w_prod;
                r_bias1 <= i_bias;
            end
            if (i_v1) begin
                r_csum  <= w_csum;
                r_bias2 <= r_bias1;
            end
            if (i_v2)
                r_bias3 <= r_bias2;
        end
    end

    // Accumulator (S3) and output register (S4): the lane state that must reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (i_en) begin
            if (i_v2)
                r_acc <= i_fresh ? w_ext : r_acc + w_ext;
            if (i_emit)
                r_out <= r_acc + r_bias3;
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/conv_kxk_array.sv
// N_FILT-wide KxK convolution engine: shared window, per-filter weights and
// bias, multi-group accumulation, 4-stage pipeline with a global stall.
module conv_kxk_array
    import conv_pkg::*;
#(
    parameter int N_FILT = N_FILT_D,
    parameter int N_CI   = N_CI_D,
    parameter int KSIZE  = KSIZE_D,
    parameter int PIX_W  = PIX_W_D,
    parameter int WT_W   = WT_W_D,
    parameter int ACC_W  = ACC_W_D
) (
    input  logic              clk,
    input  logic              rst,
    conv_kxk_array_if.slave   bus
);
    logic       w_en;
    logic       w_take;
    logic [3:1] r_vld_pipe;
    logic [3:1] r_last_pipe;
    logic       r_fresh;
    logic       r_out_valid;

    // Everything advances unless a result is waiting on downstream
    assign w_en         = !(r_out_valid && !bus.out_ready);
    assign w_take       = bus.valid_in && w_en;
    assign bus.in_ready = w_en;
    assign bus.out_valid = r_out_valid;

    // Control pipeline: stage valids, last flags, accumulator restart, out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_fresh     <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_vld_pipe  <= {r_vld_pipe[2:1], bus.valid_in};
            r_last_pipe <= {r_last_pipe[2:1], bus.valid_in && bus.last_channel};
            if (r_vld_pipe[2])
                r_fresh <= r_last_pipe[2];
            r_out_valid <= r_vld_pipe[3] && r_last_pipe[3];
        end
    end

    for (genvar gf = 0; gf < N_FILT; gf++) begin : g_lane
        conv_pe_lane #(
            .N_CI  (N_CI),
            .KSIZE (KSIZE),
            .PIX_W (PIX_W),
            .WT_W  (WT_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_en      (w_en),
            .i_take    (w_take),
            .i_mode    (bus.mode_1x1),
            .i_pixels  (bus.pixels),
            .i_weights (bus.weights[gf]),
            .i_bias    (bus.biases[gf]),
            .i_v1      (r_vld_pipe[1]),
            .i_v2      (r_vld_pipe[2]),
            .i_fresh   (r_fresh),
            .i_emit    (r_vld_pipe[3] && r_last_pipe[3]),
            .o_out     (bus.outs[gf])
        );
    end

endmodule
